// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: Gray phase codes, the phase
// type and the step classification used when comparing consecutive samples.
package quad_pkg;

   typedef logic [1:0] phase_t;

   localparam phase_t S00 = 2'b00;
   localparam phase_t S01 = 2'b01;
   localparam phase_t S11 = 2'b11;
   localparam phase_t S10 = 2'b10;

   typedef enum logic [1:0] {
      STEP_NONE    = 2'd0,
      STEP_FWD     = 2'd1,
      STEP_REV     = 2'd2,
      STEP_ILLEGAL = 2'd3
   } step_e;

   // Successor of a phase in the forward direction 00->01->11->10->00.
   function automatic phase_t next_fwd(input phase_t p);
      phase_t n;
      case (p)
         S00:     n = S01;
         S01:     n = S11;
         S11:     n = S10;
         default: n = S00;
      endcase
      return n;
   endfunction

   function automatic step_e decode_step(input phase_t prev, input phase_t cur);
      step_e res;
      res = STEP_NONE;
      if ((prev ^ cur) == 2'b11) begin
         res = STEP_ILLEGAL;
      end else if (prev != cur) begin
         res = (cur == next_fwd(prev)) ? STEP_FWD : STEP_REV;
      end
      return res;
   endfunction

endpackage

// File: rtl/quad_period_timer.sv
// Measures CE ticks between consecutive valid steps; saturates when the
// encoder stalls and flags validity once two steps have been seen.
module quad_period_timer #(
   parameter int unsigned PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                CE,
   input  logic                step,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
);

   localparam logic [PERIOD_W-1:0] TICK_MAX = '1;

   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                seen_q, seen_d;
   logic                valid_q, valid_d;
   logic                tick_sat_c;
   logic [PERIOD_W-1:0] tick_inc_c;

   // A tick arriving with the step closes the old interval, so the counter restarts at 0.
   always_comb begin
      tick_d     = tick_q;
      period_d   = period_q;
      seen_d     = seen_q;
      valid_d    = valid_q;
      tick_sat_c = (tick_q == TICK_MAX);
      tick_inc_c = (CE && !tick_sat_c) ? tick_q + PERIOD_W'(1) : tick_q;
      if (step) begin
         period_d = tick_inc_c;
         tick_d   = '0;
         seen_d   = 1'b1;
         if (seen_q) begin
            valid_d = 1'b1;
         end
      end else begin
         tick_d = tick_inc_c;
         if (tick_sat_c) begin
            period_d = TICK_MAX;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_q   <= '0;
         period_q <= '0;
         seen_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         tick_q   <= tick_d;
         period_q <= period_d;
         seen_q   <= seen_d;
         valid_q  <= valid_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature position decoder with error counting and period measurement.
// Define QUAD_BEAM_ZERO_EN to let a beam-break rising edge zero the position.
module quad_encoder_counter
   import quad_pkg::*;
#(
   parameter int unsigned POS_W    = 32,
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                CE,
   input  logic                a,
   input  logic                b,
   input  logic                beam,
   input  logic                err_clr,
   output logic [POS_W-1:0]    position,
   output logic                dir,
   output logic                step,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                homed,
   output logic                err_flag,
   output logic [ERR_W-1:0]    err_count
);

   phase_t           cur_ab_q, cur_ab_d;
   phase_t           prev_ab_q, prev_ab_d;
   logic             primed_q, primed_d;
   logic [POS_W-1:0] position_q, position_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_flag_q, err_flag_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   step_e            step_kind_c;
   logic             valid_step_c;
   logic             illegal_c;
   logic             beam_rise_c;

`ifdef QUAD_BEAM_ZERO_EN
   // [1:0] is the two-stage synchronizer, [2] holds the previous synced level.
   logic [2:0] beam_sync_q, beam_sync_d;
   logic       homed_q, homed_d;

   always_comb begin
      beam_sync_d = {beam_sync_q[1:0], beam};
      homed_d     = homed_q | beam_rise_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beam_sync_q <= '0;
         homed_q     <= 1'b0;
      end else begin
         beam_sync_q <= beam_sync_d;
         homed_q     <= homed_d;
      end
   end

   assign beam_rise_c = beam_sync_q[1] & ~beam_sync_q[2];
   assign homed       = homed_q;
`else
   logic beam_unused_c;
   assign beam_unused_c = beam;
   assign beam_rise_c   = 1'b0;
   assign homed         = 1'b0;
`endif

   // The first sample after reset only primes prev_ab so startup never decodes.
   always_comb begin
      cur_ab_d     = {a, b};
      prev_ab_d    = prev_ab_q;
      primed_d     = primed_q;
      position_d   = position_q;
      dir_d        = dir_q;
      step_d       = 1'b0;
      err_flag_d   = err_flag_q;
      err_count_d  = err_count_q;
      step_kind_c  = decode_step(prev_ab_q, cur_ab_q);
      valid_step_c = primed_q && ((step_kind_c == STEP_FWD) || (step_kind_c == STEP_REV));
      illegal_c    = primed_q && (step_kind_c == STEP_ILLEGAL);

      if (!primed_q) begin
         prev_ab_d = {a, b};
         primed_d  = 1'b1;
      end else begin
         prev_ab_d = cur_ab_q;
      end

      if (valid_step_c) begin
         step_d = 1'b1;
         if (step_kind_c == STEP_FWD) begin
            position_d = position_q + POS_W'(1);
            dir_d      = 1'b1;
         end else begin
            position_d = position_q - POS_W'(1);
            dir_d      = 1'b0;
         end
      end

      if (beam_rise_c) begin
         position_d = '0;
      end

      if (err_clr) begin
         err_flag_d  = 1'b0;
         err_count_d = '0;
      end else if (illegal_c) begin
         err_flag_d = 1'b1;
         if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_ab_q    <= S00;
         prev_ab_q   <= S00;
         primed_q    <= 1'b0;
         position_q  <= '0;
         dir_q       <= 1'b0;
         step_q      <= 1'b0;
         err_flag_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         cur_ab_q    <= cur_ab_d;
         prev_ab_q   <= prev_ab_d;
         primed_q    <= primed_d;
         position_q  <= position_d;
         dir_q       <= dir_d;
         step_q      <= step_d;
         err_flag_q  <= err_flag_d;
         err_count_q <= err_count_d;
      end
   end

   quad_period_timer #(
      .PERIOD_W(PERIOD_W)
   ) u_period (
      .clk         (clk),
      .reset       (reset),
      .CE          (CE),
      .step        (valid_step_c),
      .period      (period),
      .period_valid(period_valid)
   );

   assign position  = position_q;
   assign dir       = dir_q;
   assign step      = step_q;
   assign err_flag  = err_flag_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Scoreboard bench for quad_encoder_counter using a small-width variant
// (8-bit position/period, 4-bit error count) so wrap and saturation are reachable.
module tb_quad_encoder_counter;

   localparam int unsigned POS_W    = 8;
   localparam int unsigned PERIOD_W = 8;
   localparam int unsigned ERR_W    = 4;
   localparam int          ERR_MAX  = 15;
   localparam longint      PER_MAX  = 255;

`ifdef QUAD_BEAM_ZERO_EN
   localparam bit BEAM_EN = 1'b1;
`else
   localparam bit BEAM_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset, CE, a, b, beam, err_clr;
   logic [POS_W-1:0]    position;
   logic                dir, step, period_valid, homed, err_flag;
   logic [PERIOD_W-1:0] period;
   logic [ERR_W-1:0]    err_count;

   always #5 clk = ~clk;

   quad_encoder_counter #(
      .POS_W   (POS_W),
      .PERIOD_W(PERIOD_W),
      .ERR_W   (ERR_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .CE          (CE),
      .a           (a),
      .b           (b),
      .beam        (beam),
      .err_clr     (err_clr),
      .position    (position),
      .dir         (dir),
      .step        (step),
      .period      (period),
      .period_valid(period_valid),
      .homed       (homed),
      .err_flag    (err_flag),
      .err_count   (err_count)
   );

   typedef struct {
      logic [POS_W-1:0] pos;
      logic             dir;
      longint           edge_n;
   } exp_t;

   exp_t   exp_q[$];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   longint ce_cum = 0;
   int     steps_seen = 0;
   int     ce_mode = 0;

   // Reference model state: encoder position in the Gray cycle and expected outputs.
   logic [1:0]       gray [4];
   int               gidx;
   logic [POS_W-1:0] m_pos;
   int               m_err;
   logic             m_flag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && CE) ce_cum <= ce_cum + 1;
   end

   always @(negedge clk) begin
      case (ce_mode)
         0:       CE = 1'b0;
         1:       CE = 1'b1;
         default: CE = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every step pulse must match the oldest expected step.
   always @(negedge clk) begin : mon
      exp_t   e;
      longint pexp;
      longint base;
      int     nsteps;
      if (reset) begin
         base   = ce_cum;
         nsteps = 0;
      end else if (step === 1'b1) begin
         steps_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_step: step=1 with nothing expected, position=%0h (t=%0t)", position, $time);
         end else begin
            e = exp_q.pop_front();
            nsteps++;
            pexp = ce_cum - base;
            if (pexp > PER_MAX) pexp = PER_MAX;
            base = ce_cum;
            check("step_edge", 64'(cyc), 64'(e.edge_n));
            check("step_position", 64'(position), 64'(e.pos));
            check("step_dir", 64'(dir), 64'(e.dir));
            check("step_period", 64'(period), 64'(pexp));
            check("step_period_valid", 64'(period_valid), 64'(nsteps >= 2));
         end
      end
   end

   // kind: 1 forward, -1 reverse, 2 illegal jump, 0 hold. Called at a negedge.
   task automatic move(input int kind, input int gap, input bit zero);
      exp_t e;
      gidx = (gidx + kind + 4) % 4;
      {a, b} = gray[gidx];
      if (kind == 1 || kind == -1) begin
         m_pos = m_pos + POS_W'(kind);
         if (zero) m_pos = '0;
         e.pos    = m_pos;
         e.dir    = (kind == 1);
         e.edge_n = cyc + 2;
         exp_q.push_back(e);
      end else if (kind == 2) begin
         if (m_err < ERR_MAX) m_err++;
         m_flag = 1'b1;
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_position"}, 64'(position), 64'(0));
      check({tag, "_dir"}, 64'(dir), 64'(0));
      check({tag, "_step"}, 64'(step), 64'(0));
      check({tag, "_period"}, 64'(period), 64'(0));
      check({tag, "_period_valid"}, 64'(period_valid), 64'(0));
      check({tag, "_homed"}, 64'(homed), 64'(0));
      check({tag, "_err_flag"}, 64'(err_flag), 64'(0));
      check({tag, "_err_count"}, 64'(err_count), 64'(0));
   endtask

   task automatic model_reset();
      m_pos  = '0;
      m_err  = 0;
      m_flag = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
      gidx = 2; a = 1'b1; b = 1'b1;
      beam = 1'b0; err_clr = 1'b0; reset = 1'b1;
      model_reset();

      // Reset with a=b=1 and idle hold.
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      #2 reset = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_position", 64'(position), 64'(0));
      check("idle_err_count", 64'(err_count), 64'(0));
      check("idle_steps_seen", 64'(steps_seen), 64'(0));

      // Eight forward steps 100 clk apart with CE held high.
      ce_mode = 1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) move(1, 100, 1'b0);
      settle();
      check("fwd8_position", 64'(position), 64'(8));
      check("fwd8_dir", 64'(dir), 64'(1));
      check("fwd8_period", 64'(period), 64'(100));
      check("fwd8_period_valid", 64'(period_valid), 64'(1));
      check("fwd8_steps_seen", 64'(steps_seen), 64'(8));

      // Back to zero and three more reverse steps.
      ce_mode = 2;
      for (int i = 0; i < 11; i++) move(-1, int'($urandom_range(2, 4)), 1'b0);
      settle();
      check("rev_position", 64'(position), 64'(8'hFD));
      check("rev_dir", 64'(dir), 64'(0));

      // Climb to the positive limit, then wrap into the negative range.
      for (int i = 0; i < 130; i++) move(1, 2, 1'b0);
      settle();
      check("max_position", 64'(position), 64'(8'h7F));
      move(1, 2, 1'b0);
      settle();
      check("wrap_position", 64'(position), 64'(8'h80));

      // Random walk including holds and occasional illegal jumps.
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 4)       move(1, int'($urandom_range(2, 5)), 1'b0);
         else if (r < 8)  move(-1, int'($urandom_range(2, 5)), 1'b0);
         else if (r == 8) move(0, int'($urandom_range(2, 5)), 1'b0);
         else             move(2, int'($urandom_range(2, 5)), 1'b0);
      end
      settle();
      check("rand_position", 64'(position), 64'(m_pos));
      check("rand_err_count", 64'(err_count), 64'(m_err));
      check("rand_err_flag", 64'(err_flag), 64'(m_flag));

      // Clear, then a single 00->11 jump.
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err = 0; m_flag = 1'b0;
      while (gidx != 0) move(1, 2, 1'b0);
      settle();
      move(2, 2, 1'b0);
      settle();
      check("illegal_err_flag", 64'(err_flag), 64'(1));
      check("illegal_err_count", 64'(err_count), 64'(1));
      check("illegal_position", 64'(position), 64'(m_pos));

      // Clear coinciding with an illegal decode: clear wins.
      move(2, 1, 1'b0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err = 0; m_flag = 1'b0;
      settle();
      check("clr_race_err_flag", 64'(err_flag), 64'(0));
      check("clr_race_err_count", 64'(err_count), 64'(0));

      for (int i = 0; i < 17; i++) move(2, 2, 1'b0);
      settle();
      check("err_saturate", 64'(err_count), 64'(ERR_MAX));
      check("err_saturate_model", 64'(err_count), 64'(m_err));

      // Beam rising edge timed to land on the decode edge of a forward step.
      beam = 1'b1;
      @(negedge clk);
      move(1, 4, BEAM_EN);
      settle();
      check("beam_position", 64'(position), 64'(m_pos));
      check("beam_homed", 64'(homed), 64'(BEAM_EN));
      check("beam_dir", 64'(dir), 64'(1));
      beam = 1'b0;
      settle();

      // Asynchronous reset mid-operation, then a stall longer than the period range.
      ce_mode = 1;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_state("async_reset");
      model_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      settle();
      move(1, 3, 1'b0);
      repeat (300) @(negedge clk);
      check("stall_period", 64'(period), 64'(PER_MAX));
      check("stall_period_valid", 64'(period_valid), 64'(0));
      move(1, 3, 1'b0);
      settle();
      check("after_stall_period_valid", 64'(period_valid), 64'(1));
      check("after_stall_position", 64'(position), 64'(2));

      check("pending_steps", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
